// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//
// Command stage that sits in front of the 16-bit ALU. Commands {opcode, X, Y}
// are buffered in a DEPTH-entry FIFO. Each command is issued to the ALU with a
// one-cycle Enable pulse. The issuer then waits ALU_LAT cycles, captures
// Results/CF and returns them as a response over a valid/ready port. Only one
// command is in flight at a time, so responses come back in command order.
//
// Parameters
//   WIDTH    operand/result width
//   DEPTH    command FIFO entries (>= 2)
//   ALU_LAT  cycles after the issue cycle before Results/CF are sampled (>= 1)
//
// Ports
//   CLK, RST                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_opcode/cmd_x/cmd_y    command payload
//   alu_enable/x/y/opcode     registered drive to the ALU
//   alu_results/alu_cf        ALU outputs, sampled at the end of the wait
//   rsp_valid/rsp_ready       response handshake
//   rsp_result/rsp_cf         captured response payload
//   busy                      command in flight or queued
//   fifo_count                number of queued commands
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_opcode,
  input  logic [WIDTH-1:0]           cmd_x,
  input  logic [WIDTH-1:0]           cmd_y,
  output logic                       alu_enable,
  output logic [WIDTH-1:0]           alu_x,
  output logic [WIDTH-1:0]           alu_y,
  output logic [2:0]                 alu_opcode,
  input  logic [WIDTH-1:0]           alu_results,
  input  logic                       alu_cf,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_cf,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int LW   = $clog2(ALU_LAT+1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } cmd_t;

  state_t           state;
  state_t           state_nxt;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    wait_cnt;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             capture;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_cnt == LW'(1)) state_nxt = DONE;
      DONE:  if (rsp_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and strobes
  // -------------------------------------------------------------------------
  always_comb begin
    empty   = (fifo_count == '0);
    full    = (fifo_count == CNTW'(DEPTH));
    pop     = 1'b0;
    capture = 1'b0;
    busy    = !empty;
    case (state)
      IDLE:  pop = !empty;
      ISSUE: busy = 1'b1;
      WAIT: begin
        busy    = 1'b1;
        capture = (wait_cnt == LW'(1));
      end
      DONE: begin
        busy = 1'b1;
        pop  = rsp_ready && !empty;
      end
      default: ;
    endcase
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // accept when the response is being handed off.
    cmd_ready = !RST && (!full || pop);
    push      = cmd_valid && cmd_ready;
  end

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; only pointers and the count do.
  // Stale entries are never read because the count gates every pop.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {cmd_opcode, cmd_x, cmd_y};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // ALU drive, wait counter and response capture
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_enable <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_opcode <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
    end else begin
      // Every pop leads into a single ISSUE cycle, so registering the pop
      // gives exactly one Enable pulse. NOP never enables the ALU.
      alu_enable <= pop && (head.opcode != 3'b000);
      if (pop) begin
        alu_x      <= head.x;
        alu_y      <= head.y;
        alu_opcode <= head.opcode;
      end

      if (state == ISSUE)
        wait_cnt <= LW'(ALU_LAT);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;

      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= (alu_opcode == 3'b000) ? '0 : alu_results;
        rsp_cf     <= (alu_opcode == 3'b000) ? 1'b0 : alu_cf;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Directed bench for alu_cmd_issuer with a combinational ALU stand-in. Single
// commands come from a vector table. Hand-written sequences cover the queueing,
// full-FIFO push/pop and mid-operation reset cases.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int LAT     = ALU_LAT + 2;

  logic              CLK;
  logic              RST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [WIDTH-1:0]  cmd_x;
  logic [WIDTH-1:0]  cmd_y;
  logic              alu_enable;
  logic [WIDTH-1:0]  alu_x;
  logic [WIDTH-1:0]  alu_y;
  logic [2:0]        alu_opcode;
  logic [WIDTH-1:0]  alu_results;
  logic              alu_cf;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_cf;
  logic              busy;
  logic [2:0]        fifo_count;

  alu_cmd_issuer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .alu_enable (alu_enable),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_opcode (alu_opcode),
    .alu_results(alu_results),
    .alu_cf     (alu_cf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cf     (rsp_cf),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU stand-in. Opcode 000 drives garbage so the issuer must zero NOP responses.
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    case (op)
      3'b000:  return {1'b1, 16'hDEAD};
      3'b001:  return {1'b0, x} + {1'b0, y};
      3'b010:  return {1'b0, x} - {1'b0, y};
      3'b011:  return {1'b0, x & y};
      3'b100:  return {1'b0, x | y};
      3'b101:  return {1'b0, x ^ y};
      3'b110:  return {x, 1'b0};
      default: return {1'b0, y};
    endcase
  endfunction

  assign {alu_cf, alu_results} = alu_f(alu_opcode, alu_x, alu_y);

  // Enable pulses counted once per high cycle.
  int pulses = 0;
  always @(negedge CLK) if (alu_enable) pulses++;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic        cf;
  } vec_t;

  vec_t vecs [9];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    cmd_opcode = op;
    cmd_x      = x;
    cmd_y      = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int base;
    logic [15:0] exp_q [5];

    vecs[0] = '{3'b001, 16'h0003, 16'h0004, 16'h0007, 1'b0};
    vecs[1] = '{3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{3'b000, 16'h1234, 16'h5678, 16'h0000, 1'b0};
    vecs[3] = '{3'b010, 16'h0005, 16'h0007, 16'hFFFE, 1'b1};
    vecs[4] = '{3'b011, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[5] = '{3'b100, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0};
    vecs[6] = '{3'b101, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[7] = '{3'b110, 16'h8001, 16'h0000, 16'h0002, 1'b1};
    vecs[8] = '{3'b111, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0};

    RST       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    drive_cmd(3'b000, 16'h0000, 16'h0000);
    tick();
    tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_x", 32'(alu_x), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    // Single commands from the table
    for (int i = 0; i < 9; i++) begin
      base = pulses;
      drive_cmd(vecs[i].op, vecs[i].x, vecs[i].y);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'd1);
      wait_rsp(k);
      check($sformatf("v%0d_latency", i), 32'(k), 32'(LAT));
      check($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
      check($sformatf("v%0d_cf", i), 32'(rsp_cf), 32'(vecs[i].cf));
      tick();
      check($sformatf("v%0d_hold_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_hold_result", i), 32'(rsp_result), 32'(vecs[i].res));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_valid_clr", i), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_pulses", i), 32'(pulses - base), (vecs[i].op != 3'b000) ? 32'd1 : 32'd0);
    end

    // Queueing with the response held: one in flight plus a full FIFO
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(3'b001, 16'(i), 16'h0100);
      cmd_valid = 1'b1;
      check($sformatf("q%0d_ready", i), 32'(cmd_ready), 32'd1);
      tick();
      if (i == 3) check("q_count_after_4", 32'(fifo_count), 32'd3);
    end
    drive_cmd(3'b001, 16'h0FFF, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_ready_%0d", i), 32'(cmd_ready), 32'd0);
      check($sformatf("full_count_%0d", i), 32'(fifo_count), 32'(DEPTH));
      tick();
    end
    cmd_valid = 1'b0;
    check("q_rsp0_valid", 32'(rsp_valid), 32'd1);
    check("q_rsp0_result", 32'(rsp_result), 32'h0100);

    // Full FIFO: push and pop in the same cycle
    drive_cmd(3'b001, 16'h00FF, 16'h0100);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("pp_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'(DEPTH));

    exp_q[0] = 16'h0101;
    exp_q[1] = 16'h0102;
    exp_q[2] = 16'h0103;
    exp_q[3] = 16'h0104;
    exp_q[4] = 16'h01FF;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(k);
      check($sformatf("drain%0d_valid", j), 32'(rsp_valid), 32'd1);
      check($sformatf("drain%0d_result", j), 32'(rsp_result), 32'(exp_q[j]));
      tick();
    end
    rsp_ready = 1'b0;
    tick();
    check("drain_pulses", 32'(pulses - base), 32'd6);
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    // Reset in WAIT with two commands queued
    for (int i = 0; i < 3; i++) begin
      drive_cmd(3'b001, 16'(16'h0A00 + i), 16'h0001);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("rw_count", 32'(fifo_count), 32'd2);
    check("rw_enable", 32'(alu_enable), 32'd0);
    check("rw_opcode", 32'(alu_opcode), 32'd1);
    check("rw_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("rw_ready_in_rst", 32'(cmd_ready), 32'd0);
    tick();
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_fifo_count", 32'(fifo_count), 32'd0);
    check("rw_alu_x", 32'(alu_x), 32'd0);
    check("rw_alu_y", 32'(alu_y), 32'd0);
    check("rw_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rw_alu_enable", 32'(alu_enable), 32'd0);
    check("rw_busy_after", 32'(busy), 32'd0);
    RST = 1'b0;
    base = pulses;
    repeat (10) tick();
    check("rw_no_pulses", 32'(pulses - base), 32'd0);
    check("rw_still_idle", 32'(rsp_valid), 32'd0);
    check("rw_still_empty", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
